alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler.sv | 139 +++++++++++++
 tb/tb_alu_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin front end for two requesters sharing one ALU,
// holding operands for HOLD_CYCLES before capturing the result into a response.
module alu_scheduler #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [5:0]  r0_instr,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [15:0] r0_value,
    input  logic        r0_highlow,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic [31:0] r0_rsp_data,
    output logic        r0_rsp_flag,
    output logic        r0_rsp_err,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [5:0]  r1_instr,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [15:0] r1_value,
    input  logic        r1_highlow,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [31:0] r1_rsp_data,
    output logic        r1_rsp_flag,
    output logic        r1_rsp_err,
    output logic [5:0]  alu_instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [15:0] alu_value,
    output logic        alu_highlow,
    output logic        alu_en,
    input  logic [31:0] alu_c,
    input  logic        alu_f3,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
    state_t      state_q, state_d;
    logic        ptr_q, ptr_d, own_q, own_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  instr_q, instr_d;
    logic [31:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [15:0] value_q, value_d;
    logic        hl_q, hl_d, flag_q, flag_d, err_q, err_d;
    logic        req, sel, legal, accept, run, rsp_done;
    logic [5:0]  sel_instr;

    // Both valid: the pointer decides; otherwise the lone valid requester wins.
    assign req       = r0_valid | r1_valid;
    assign sel       = (r0_valid & r1_valid) ? ptr_q : ~r0_valid;
    assign sel_instr = sel ? r1_instr : r0_instr;
    assign legal     = sel_instr <= 6'd10;
    assign accept    = state_q == IDLE && req;
    assign run       = state_q == EXEC || state_q == CAPT;
    assign rsp_done  = own_q ? r1_rsp_ready : r0_rsp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            own_q   <= 1'b0;
            cnt_q   <= 4'd0;
            instr_q <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            value_q <= 16'd0;
            hl_q    <= 1'b0;
            data_q  <= 32'd0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            value_q <= value_d;
            hl_q    <= hl_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = legal ? EXEC : RESP;
            EXEC:    if (cnt_q == 4'd0) state_d = CAPT;
            CAPT:    state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand and response registers; response regs clear on each grant so
    // the uncaptured field of a legal op and both fields of an illegal op read 0.
    always_comb begin
        ptr_d   = accept ? ~sel : ptr_q;
        own_d   = accept ? sel : own_q;
        instr_d = accept ? sel_instr : instr_q;
        a_d     = accept ? (sel ? r1_a : r0_a) : a_q;
        b_d     = accept ? (sel ? r1_b : r0_b) : b_q;
        value_d = accept ? (sel ? r1_value : r0_value) : value_q;
        hl_d    = accept ? (sel ? r1_highlow : r0_highlow) : hl_q;
        cnt_d   = accept ? 4'(HOLD_CYCLES - 1) :
                  (state_q == EXEC && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        data_d  = accept ? 32'd0 : (state_q == CAPT && instr_q <= 6'd7) ? alu_c : data_q;
        flag_d  = accept ? 1'b0 : (state_q == CAPT && instr_q >= 6'd8) ? alu_f3 : flag_q;
        err_d   = accept ? ~legal : err_q;
    end

    always_comb begin
        r0_ready     = !reset && accept && !sel;
        r1_ready     = !reset && accept && sel;
        r0_rsp_valid = state_q == RESP && !own_q;
        r1_rsp_valid = state_q == RESP && own_q;
        r0_rsp_data  = r0_rsp_valid ? data_q : 32'd0;
        r0_rsp_flag  = r0_rsp_valid && flag_q;
        r0_rsp_err   = r0_rsp_valid && err_q;
        r1_rsp_data  = r1_rsp_valid ? data_q : 32'd0;
        r1_rsp_flag  = r1_rsp_valid && flag_q;
        r1_rsp_err   = r1_rsp_valid && err_q;
        alu_en       = run;
        alu_instr    = run ? instr_q : 6'd0;
        alu_a        = run ? a_q : 32'd0;
        alu_b        = run ? b_q : 32'd0;
        alu_value    = run ? value_q : 16'd0;
        alu_highlow  = run && hl_q;
        busy         = state_q != IDLE;
    end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: drives a HOLD_CYCLES=1 and a HOLD_CYCLES=4 instance with shared
// stimulus and compares both against a transaction-timeline model every cycle.
module tb_alu_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic        v[2], ohl[2], rr[2];
    logic [5:0]  ins[2];
    logic [31:0] oa[2], ob[2];
    logic [15:0] ov[2];
    logic        rdy[2][2], rv[2][2], rf[2][2], re[2][2];
    logic [31:0] rd[2][2];
    logic [5:0]  ai[2];
    logic [31:0] aa[2], ab[2], ac[2];
    logic [15:0] av[2];
    logic        ah[2], aen[2], af[2], bz[2];

    int checks = 0, failures = 0, cyc = 0;
    logic        m_busy[2] = '{1'b0, 1'b0};
    logic        m_ptr[2] = '{1'b0, 1'b0};
    logic        m_own[2], m_hl[2];
    int          m_t[2];
    logic [5:0]  m_op[2];
    logic [31:0] m_a[2], m_b[2];
    logic [15:0] m_v[2];
    int          rdy_cyc[2] = '{0, 0}, rsp_cyc[2] = '{0, 0}, en_cnt[2] = '{0, 0}, r1_cnt[2] = '{0, 0};
    logic [31:0] last_d[2];
    logic        last_f[2], last_e[2], last_n[2];
    int          gq[$];

    always #5 clock = ~clock;

    // Reference ALU: non-compare ops drive a noise flag, compares drive noise data,
    // so a scheduler that captures the wrong field is exposed.
    function automatic logic [32:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [15:0] val, input logic hl);
        logic [31:0] d;
        logic f;
        d = a - b;
        f = a[0] ^ b[0];
        case (op)
            6'd0:  d = a + b;
            6'd1:  d = a - b;
            6'd2:  d = a & b;
            6'd3:  d = a | b;
            6'd4:  d = a ^ b;
            6'd5:  d = a << b[4:0];
            6'd6:  d = a >> b[4:0];
            6'd7:  d = hl ? {val, 16'h0} : {16'h0, val};
            6'd8:  f = a == b;
            6'd9:  f = a < b;
            6'd10: f = a > b;
            default: ;
        endcase
        return {f, d};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_scheduler #(.HOLD_CYCLES(g == 0 ? 1 : 4)) dut (
            .clock(clock), .reset(reset),
            .r0_valid(v[0]), .r0_ready(rdy[g][0]), .r0_instr(ins[0]), .r0_a(oa[0]), .r0_b(ob[0]),
            .r0_value(ov[0]), .r0_highlow(ohl[0]), .r0_rsp_valid(rv[g][0]), .r0_rsp_ready(rr[0]),
            .r0_rsp_data(rd[g][0]), .r0_rsp_flag(rf[g][0]), .r0_rsp_err(re[g][0]),
            .r1_valid(v[1]), .r1_ready(rdy[g][1]), .r1_instr(ins[1]), .r1_a(oa[1]), .r1_b(ob[1]),
            .r1_value(ov[1]), .r1_highlow(ohl[1]), .r1_rsp_valid(rv[g][1]), .r1_rsp_ready(rr[1]),
            .r1_rsp_data(rd[g][1]), .r1_rsp_flag(rf[g][1]), .r1_rsp_err(re[g][1]),
            .alu_instr(ai[g]), .alu_a(aa[g]), .alu_b(ab[g]), .alu_value(av[g]), .alu_highlow(ah[g]),
            .alu_en(aen[g]), .alu_c(ac[g]), .alu_f3(af[g]), .busy(bz[g])
        );
        assign {af[g], ac[g]} = alu_fn(ai[g], aa[g], ab[g], av[g], ah[g]);
    end

    function automatic int hold(input int k);
        return k == 0 ? 1 : 4;
    endfunction

    function automatic logic winner(input int k);
        if (!v[0]) return 1'b1;
        if (!v[1]) return 1'b0;
        return m_ptr[k];
    endfunction

    // Legal op granted in cycle t: ALU driven t+1..t+H+1, response from t+H+2.
    // Illegal op: response from t+1, ALU never driven.
    function automatic logic in_exec(input int k, input int c);
        return m_busy[k] && m_op[k] <= 6'd10 && c > m_t[k] && c <= m_t[k] + hold(k) + 1;
    endfunction

    function automatic logic in_rsp(input int k, input int c);
        return m_busy[k] && (m_op[k] > 6'd10 ? c > m_t[k] : c >= m_t[k] + hold(k) + 2);
    endfunction

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] <= 1'b0;
                m_ptr[k]  <= 1'b0;
            end else if (!m_busy[k] && (v[0] || v[1])) begin
                m_busy[k] <= 1'b1;
                m_own[k]  <= winner(k);
                m_ptr[k]  <= !winner(k);
                m_t[k]    <= cyc;
                m_op[k]   <= ins[winner(k)];
                m_a[k]    <= oa[winner(k)];
                m_b[k]    <= ob[winner(k)];
                m_v[k]    <= ov[winner(k)];
                m_hl[k]   <= ohl[winner(k)];
            end else if (in_rsp(k, cyc) && rr[m_own[k]]) begin
                m_busy[k] <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        logic [32:0] r;
        logic en, s, g;
        if (cyc > 0) begin
            for (int k = 0; k < 2; k++) begin
                en = in_exec(k, cyc);
                r = alu_fn(m_op[k], m_a[k], m_b[k], m_v[k], m_hl[k]);
                check("busy", k, 32'(bz[k]), 32'(m_busy[k]));
                check("alu_en", k, 32'(aen[k]), 32'(en));
                check("alu_instr", k, 32'(ai[k]), en ? 32'(m_op[k]) : 32'd0);
                check("alu_a", k, aa[k], en ? m_a[k] : 32'd0);
                check("alu_b", k, ab[k], en ? m_b[k] : 32'd0);
                check("alu_value", k, 32'(av[k]), en ? 32'(m_v[k]) : 32'd0);
                check("alu_highlow", k, 32'(ah[k]), 32'(en && m_hl[k]));
                for (int n = 0; n < 2; n++) begin
                    g = !m_busy[k] && !reset && (v[0] || v[1]) && winner(k) == 1'(n);
                    s = in_rsp(k, cyc) && m_own[k] == 1'(n);
                    check($sformatf("r%0d_ready", n), k, 32'(rdy[k][n]), 32'(g));
                    check($sformatf("r%0d_rsp_valid", n), k, 32'(rv[k][n]), 32'(s));
                    check($sformatf("r%0d_rsp_data", n), k, rd[k][n], (s && m_op[k] <= 6'd7) ? r[31:0] : 32'd0);
                    check($sformatf("r%0d_rsp_flag", n), k, 32'(rf[k][n]),
                          32'(s && m_op[k] >= 6'd8 && m_op[k] <= 6'd10 && r[32]));
                    check($sformatf("r%0d_rsp_err", n), k, 32'(re[k][n]), 32'(s && m_op[k] > 6'd10));
                    if (rdy[k][n]) begin
                        rdy_cyc[k] = cyc;
                        if (k == 0) gq.push_back(n);
                        if (n == 1) r1_cnt[k]++;
                    end
                    if (rv[k][n] && rsp_cyc[k] <= rdy_cyc[k]) begin
                        rsp_cyc[k] = cyc;
                        last_d[k] = rd[k][n];
                        last_f[k] = rf[k][n];
                        last_e[k] = re[k][n];
                        last_n[k] = 1'(n);
                    end
                end
                if (aen[k]) en_cnt[k]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int n, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        v[n] = 1'b1;
        ins[n] = op;
        oa[n] = a;
        ob[n] = b;
        ov[n] = 16'($urandom);
        ohl[n] = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (bz[0] || bz[1]); i++) tick(1);
        check("idle_timeout", 0, 32'(bz[0] || bz[1]), 32'd0);
    endtask

    initial begin
        int e0, e1, g0, c0, c1;
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            v[n] = 1'b0; ins[n] = 6'd0; oa[n] = 32'd0; ob[n] = 32'd0;
            ov[n] = 16'd0; ohl[n] = 1'b0; rr[n] = 1'b1;
        end
        tick(3);
        check("reset_busy", 0, 32'(bz[0]), 32'd0);
        check("reset_alu_en", 1, 32'(aen[1]), 32'd0);
        reset = 1'b0;
        tick(1);
        // add 5+7 on both instances: latency H+2, ALU enabled H+1 cycles
        e0 = en_cnt[0]; e1 = en_cnt[1];
        set_req(0, 6'd0, 32'd5, 32'd7);
        tick(1);
        v[0] = 1'b0;
        tick(10);
        check("add_latency", 0, 32'(rsp_cyc[0] - rdy_cyc[0]), 32'd3);
        check("add_latency", 1, 32'(rsp_cyc[1] - rdy_cyc[1]), 32'd6);
        check("add_data", 0, last_d[0], 32'd12);
        check("add_data", 1, last_d[1], 32'd12);
        check("add_flag_err", 0, {30'd0, last_f[0], last_e[0]}, 32'd0);
        check("add_en_cycles", 0, 32'(en_cnt[0] - e0), 32'd2);
        check("add_en_cycles", 1, 32'(en_cnt[1] - e1), 32'd5);
        // illegal opcode 12 from r1
        e0 = en_cnt[0]; e1 = en_cnt[1];
        set_req(1, 6'd12, $urandom, $urandom);
        tick(1);
        v[1] = 1'b0;
        tick(5);
        check("illegal_latency", 0, 32'(rsp_cyc[0] - rdy_cyc[0]), 32'd1);
        check("illegal_latency", 1, 32'(rsp_cyc[1] - rdy_cyc[1]), 32'd1);
        check("illegal_rsp", 0, {last_d[0][29:0], last_n[0], last_e[0]}, 32'd3);
        check("illegal_flag", 0, 32'(last_f[0]), 32'd0);
        check("illegal_en", 0, 32'(en_cnt[0] - e0 + en_cnt[1] - e1), 32'd0);
        // both requesting eq 3,3 continuously: grants alternate
        g0 = gq.size();
        set_req(0, 6'd8, 32'd3, 32'd3);
        set_req(1, 6'd8, 32'd3, 32'd3);
        tick(30);
        v[0] = 1'b0; v[1] = 1'b0;
        check("rr_grants", 0, 32'(gq.size() >= g0 + 4), 32'd1);
        check("rr_order", 0, {28'd0, gq[g0][0], gq[g0 + 1][0], gq[g0 + 2][0], gq[g0 + 3][0]}, 32'b0101);
        check("eq_flag", 0, 32'(last_f[0]), 32'd1);
        // lt 2,9 with response held off; r1 must not be granted meanwhile
        wait_idle();
        rr[0] = 1'b0; rr[1] = 1'b0;
        c0 = r1_cnt[0]; c1 = r1_cnt[1];
        set_req(0, 6'd9, 32'd2, 32'd9);
        tick(1);
        v[0] = 1'b0;
        set_req(1, 6'd0, 32'd1, 32'd1);
        tick(14);
        check("hold_r1_grants", 0, 32'(r1_cnt[0] - c0 + r1_cnt[1] - c1), 32'd0);
        check("hold_rsp_valid", 0, {30'd0, rv[0][0], rv[1][0]}, 32'd3);
        check("hold_flag", 0, {30'd0, rf[0][0], rf[1][0]}, 32'd3);
        check("hold_busy", 0, {30'd0, bz[0], bz[1]}, 32'd3);
        rr[0] = 1'b1; rr[1] = 1'b1;
        tick(12);
        check("release_r1_granted", 0, 32'(r1_cnt[0] - c0 > 0), 32'd1);
        v[1] = 1'b0;
        // reset in the middle of an operation discards it
        wait_idle();
        set_req(0, 6'd0, 32'd10, 32'd20);
        tick(1);
        v[0] = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midreset_busy", 0, {30'd0, bz[0], bz[1]}, 32'd0);
        check("midreset_alu_en", 0, {30'd0, aen[0], aen[1]}, 32'd0);
        tick(10);
        check("midreset_no_rsp", 0, 32'(rsp_cyc[0] > rdy_cyc[0] || rsp_cyc[1] > rdy_cyc[1]), 32'd0);
        set_req(0, 6'd0, 32'd5, 32'd7);
        tick(1);
        v[0] = 1'b0;
        tick(10);
        check("post_reset_data", 1, last_d[1], 32'd12);
        check("post_reset_latency", 1, 32'(rsp_cyc[1] - rdy_cyc[1]), 32'd6);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 199) == 0;
            for (int n = 0; n < 2; n++) begin
                v[n] = 1'($urandom_range(0, 1));
                ins[n] = $urandom_range(0, 7) == 0 ? 6'($urandom_range(11, 63)) : 6'($urandom_range(0, 10));
                oa[n] = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : 32'($urandom);
                ob[n] = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : 32'($urandom);
                ov[n] = 16'($urandom);
                ohl[n] = 1'($urandom);
                rr[n] = $urandom_range(0, 9) < 7;
            end
            tick(1);
        end
        reset = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0;
        rr[0] = 1'b1; rr[1] = 1'b1;
        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
